div_seq: RTL

DIV_SEQ -- requirements
Module: div_seq

---
 rtl/div_seq_if.sv | 39 +++
 rtl/div_seq.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/div_seq_if.sv
// div_seq_if: job/result handshake and divider register-bus interfaces used by div_seq
interface div_job_if;
    logic        job_valid;
    logic        job_ready;
    logic [31:0] job_a;
    logic [31:0] job_b;
    logic        job_uns;
    logic        res_valid;
    logic        res_ready;
    logic [31:0] res_q;
    logic [31:0] res_r;
    logic        res_err;
    modport master (
        output job_valid, job_a, job_b, job_uns, res_ready,
        input  job_ready, res_valid, res_q, res_r, res_err
    );
    modport slave (
        input  job_valid, job_a, job_b, job_uns, res_ready,
        output job_ready, res_valid, res_q, res_r, res_err
    );
endinterface

interface div_cbus_if;
    logic        c_valid;
    logic        c_write;
    logic [31:0] c_addr;
    logic [31:0] c_wdata;
    logic [1:0]  c_size;
    logic        c_ready;
    logic [31:0] c_rdata;
    modport master (
        output c_valid, c_write, c_addr, c_wdata, c_size,
        input  c_ready, c_rdata
    );
    modport slave (
        input  c_valid, c_write, c_addr, c_wdata, c_size,
        output c_ready, c_rdata
    );
endinterface

// File: rtl/div_seq.sv
// div_seq: drives a memory-mapped divider through one job (write operands, start, poll, clear, read results)
module div_seq #(
    parameter logic [31:0] BASE     = 32'h0,
    parameter int          RSP_TMO  = 15,
    parameter int          POLL_MAX = 63
) (
    input  logic       fclk,
    input  logic       frstb,
    div_job_if.slave   job_s,
    div_cbus_if.master cbus_m,
    output logic       seq_busy_o
);
    localparam int TW = $clog2(RSP_TMO + 1);
    localparam int PW = $clog2(POLL_MAX + 1);
    localparam logic [31:0] A_ADDR   = BASE;
    localparam logic [31:0] B_ADDR   = BASE + 32'h04;
    localparam logic [31:0] Q_ADDR   = BASE + 32'h08;
    localparam logic [31:0] R_ADDR   = BASE + 32'h0C;
    localparam logic [31:0] CTL_ADDR = BASE + 32'h10;

    typedef enum logic [3:0] {
        IDLE, WR_A, WR_B, WR_GO, SETTLE, POLL, WR_CLR, RD_Q, RD_R, OUT
    } state_t;

    state_t        state_q, state_d;
    logic          pend_q, pend_d;
    logic          settle_q, settle_d;
    logic          uns_q, uns_d;
    logic          err_q, err_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic [PW-1:0] poll_q, poll_d;
    logic [31:0]   a_q, a_d, b_q, b_d, rq_q, rq_d, rr_q, rr_d;
    logic          bus_st, ack, abort;

    // pend_q marks that the request pulse has gone out and we are waiting for c_ready
    assign bus_st = state_q inside {WR_A, WR_B, WR_GO, POLL, WR_CLR, RD_Q, RD_R};
    assign ack    = bus_st && pend_q && cbus_m.c_ready;
    assign abort  = (bus_st && pend_q && !cbus_m.c_ready && tmo_q == TW'(RSP_TMO - 1))
                 || (state_q == POLL && ack && cbus_m.c_rdata[0] && poll_q == PW'(POLL_MAX - 1));

    assign cbus_m.c_valid = bus_st && !pend_q;
    assign cbus_m.c_write = state_q inside {WR_A, WR_B, WR_GO, WR_CLR};
    assign cbus_m.c_size  = 2'b10;
    assign cbus_m.c_addr  = (state_q == WR_A) ? A_ADDR :
                            (state_q == WR_B) ? B_ADDR :
                            (state_q == RD_Q) ? Q_ADDR :
                            (state_q == RD_R) ? R_ADDR :
                            (state_q inside {WR_GO, POLL, WR_CLR}) ? CTL_ADDR : 32'h0;
    assign cbus_m.c_wdata = (state_q == WR_A)   ? a_q :
                            (state_q == WR_B)   ? b_q :
                            (state_q == WR_GO)  ? {30'b0, uns_q, 1'b1} :
                            (state_q == WR_CLR) ? {30'b0, uns_q, 1'b0} : 32'h0;

    assign job_s.job_ready = state_q == IDLE;
    assign job_s.res_valid = state_q == OUT;
    assign job_s.res_q     = rq_q;
    assign job_s.res_r     = rr_q;
    assign job_s.res_err   = err_q;
    assign seq_busy_o      = state_q != IDLE;

    // next-state: generic request/response/timeout handling, then per-state progress, abort overrides all
    always_comb begin
        state_d  = state_q;
        pend_d   = pend_q;
        settle_d = settle_q;
        tmo_d    = tmo_q;
        poll_d   = poll_q;
        a_d      = a_q;
        b_d      = b_q;
        uns_d    = uns_q;
        rq_d     = rq_q;
        rr_d     = rr_q;
        err_d    = err_q;
        if (bus_st) begin
            pend_d = !pend_q || !cbus_m.c_ready;
            tmo_d  = (pend_q && !cbus_m.c_ready) ? tmo_q + 1'b1 : '0;
        end
        case (state_q)
            IDLE: if (job_s.job_valid) begin
                state_d = WR_A;
                a_d     = job_s.job_a;
                b_d     = job_s.job_b;
                uns_d   = job_s.job_uns;
                poll_d  = '0;
            end
            WR_A:   if (ack) state_d = WR_B;
            WR_B:   if (ack) state_d = WR_GO;
            WR_GO:  if (ack) begin
                state_d  = SETTLE;
                settle_d = 1'b0;
            end
            SETTLE: begin
                settle_d = 1'b1;
                if (settle_q) state_d = POLL;
            end
            POLL:   if (ack) begin
                if (cbus_m.c_rdata[0]) poll_d = poll_q + 1'b1;
                else state_d = WR_CLR;
            end
            WR_CLR: if (ack) state_d = RD_Q;
            RD_Q:   if (ack) begin
                rq_d    = cbus_m.c_rdata;
                state_d = RD_R;
            end
            RD_R:   if (ack) begin
                rr_d    = cbus_m.c_rdata;
                err_d   = 1'b0;
                state_d = OUT;
            end
            OUT:    if (job_s.res_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (abort) begin
            state_d = OUT;
            pend_d  = 1'b0;
            tmo_d   = '0;
            rq_d    = '1;
            rr_d    = '1;
            err_d   = 1'b1;
        end
    end

    // state and datapath registers, cleared by the shared asynchronous reset
    always_ff @(posedge fclk or negedge frstb) begin
        if (!frstb) begin
            state_q  <= IDLE;
            pend_q   <= 1'b0;
            settle_q <= 1'b0;
            tmo_q    <= '0;
            poll_q   <= '0;
            a_q      <= '0;
            b_q      <= '0;
            uns_q    <= 1'b0;
            rq_q     <= '0;
            rr_q     <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            pend_q   <= pend_d;
            settle_q <= settle_d;
            tmo_q    <= tmo_d;
            poll_q   <= poll_d;
            a_q      <= a_d;
            b_q      <= b_d;
            uns_q    <= uns_d;
            rq_q     <= rq_d;
            rr_q     <= rr_d;
            err_q    <= err_d;
        end
    end
endmodule
